// File: rtl/axi_stall_pkg.sv
// Shared constants and helpers for the AXI handshake stall injector.
package axi_stall_pkg;

    localparam int CH_AR  = 0;
    localparam int CH_R   = 1;
    localparam int CH_AW  = 2;
    localparam int CH_W   = 3;
    localparam int CH_B   = 4;
    localparam int NUM_CH = 5;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_FALLBACK = 16'hACE1;

    // Per-channel seed: base ^ (0x1F35 * (k+1)); an all-zero LFSR would lock up.
    function automatic logic [15:0] chan_seed(input logic [15:0] base, input int k);
        logic [15:0] s;
        s = base ^ 16'(16'h1F35 * 16'(k + 1));
        return (s == 16'h0000) ? LFSR_FALLBACK : s;
    endfunction

endpackage

// File: rtl/axi_chan_gate.sv
// One channel's random stall gate: LFSR, valid-commit flag, bounded stall run
// counter and saturating stall counter. Gating is purely combinational.
module axi_chan_gate
    import axi_stall_pkg::*;
#(
    parameter int          CH_IDX    = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_STALL = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inject_en,
    input  logic [7:0]  thresh,
    input  logic        src_valid,
    input  logic        dst_ready,
    output logic        dst_valid,
    output logic        src_ready,
    output logic [31:0] stall_cnt
);

    localparam logic [15:0] SEED = chan_seed(LFSR_SEED, CH_IDX);
    localparam logic [7:0]  CAP  = 8'(MAX_STALL);

    logic [15:0] lfsr_q, lfsr_d;
    logic        committed_q, committed_d;
    logic [7:0]  run_q, run_d;
    logic [31:0] cnt_q, cnt_d;
    logic        gate_open;
    logic        stall;

    // Gate decision, handshake gating and next-state for all channel state.
    always_comb begin
        // Once a valid has been shown downstream it must stay up, so a
        // committed channel bypasses the random gate until the handshake.
        gate_open = ~inject_en | (lfsr_q[7:0] >= thresh) | (run_q == CAP) | committed_q;
        dst_valid = src_valid & gate_open & rst_n;
        src_ready = dst_ready & gate_open & rst_n;
        stall     = src_valid & ~gate_open;

        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

        committed_d = committed_q;
        if (dst_valid) begin
            committed_d = ~dst_ready;
        end

        run_d = run_q;
        if (gate_open) begin
            run_d = 8'h00;
        end else if (stall) begin
            run_d = run_q + 8'h01;
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'h1;
        end
    end

    // State registers; reset reloads the seed and clears all tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= SEED;
            committed_q <= 1'b0;
            run_q       <= 8'h00;
            cnt_q       <= 32'h0;
        end else begin
            lfsr_q      <= lfsr_d;
            committed_q <= committed_d;
            run_q       <= run_d;
            cnt_q       <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: rtl/axi_stall_injector.sv
// AXI4 stall injector between a CPU master and axi_ram. Five channel gates
// handle valid/ready; payloads pass straight through with return-channel
// payloads zeroed whenever their valid is low.
module axi_stall_injector
    import axi_stall_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 30,
    parameter int          ID_WIDTH   = 4,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          MAX_STALL  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inject_en,
    input  logic [39:0]           stall_thresh,
    output logic [159:0]          stall_cnt,
    // AR
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    // R
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    // AW
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    // W
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    // B
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    logic [NUM_CH-1:0] ch_sv, ch_dr, ch_dv, ch_sr;

    // Source valid / destination ready per channel (R and B flow m -> s).
    assign ch_sv = {m_axi_bvalid, s_axi_wvalid, s_axi_awvalid, m_axi_rvalid, s_axi_arvalid};
    assign ch_dr = {s_axi_bready, m_axi_wready, m_axi_awready, s_axi_rready, m_axi_arready};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        axi_chan_gate #(
            .CH_IDX   (k),
            .LFSR_SEED(LFSR_SEED),
            .MAX_STALL(MAX_STALL)
        ) u_gate (
            .clk      (clk),
            .rst_n    (rst_n),
            .inject_en(inject_en),
            .thresh   (stall_thresh[8*k +: 8]),
            .src_valid(ch_sv[k]),
            .dst_ready(ch_dr[k]),
            .dst_valid(ch_dv[k]),
            .src_ready(ch_sr[k]),
            .stall_cnt(stall_cnt[32*k +: 32])
        );
    end

    // Gated handshakes back onto the two bundles.
    assign m_axi_arvalid = ch_dv[CH_AR];
    assign s_axi_arready = ch_sr[CH_AR];
    assign s_axi_rvalid  = ch_dv[CH_R];
    assign m_axi_rready  = ch_sr[CH_R];
    assign m_axi_awvalid = ch_dv[CH_AW];
    assign s_axi_awready = ch_sr[CH_AW];
    assign m_axi_wvalid  = ch_dv[CH_W];
    assign s_axi_wready  = ch_sr[CH_W];
    assign s_axi_bvalid  = ch_dv[CH_B];
    assign m_axi_bready  = ch_sr[CH_B];

    // Forward payloads pass through untouched.
    assign m_axi_arid    = s_axi_arid;
    assign m_axi_araddr  = s_axi_araddr;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arlock  = s_axi_arlock;
    assign m_axi_arcache = s_axi_arcache;
    assign m_axi_arprot  = s_axi_arprot;
    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awaddr  = s_axi_awaddr;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awlock  = s_axi_awlock;
    assign m_axi_awcache = s_axi_awcache;
    assign m_axi_awprot  = s_axi_awprot;
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_wlast   = s_axi_wlast;

    // Return payloads are zero whenever the master-facing valid is low.
    assign s_axi_rid   = s_axi_rvalid ? m_axi_rid   : '0;
    assign s_axi_rdata = s_axi_rvalid ? m_axi_rdata : '0;
    assign s_axi_rresp = s_axi_rvalid ? m_axi_rresp : '0;
    assign s_axi_rlast = s_axi_rvalid & m_axi_rlast;
    assign s_axi_bid   = s_axi_bvalid ? m_axi_bid   : '0;
    assign s_axi_bresp = s_axi_bvalid ? m_axi_bresp : '0;

endmodule

// File: tb/tb_axi_stall_injector.sv
// Bench for axi_stall_injector: reset, table vectors, stall-cap / commit /
// burst sequences, and randomized traffic against a cycle reference model.
module tb_axi_stall_injector;

    localparam int          DW        = 32;
    localparam int          AWD       = 30;
    localparam int          IW        = 4;
    localparam int          SW        = DW / 8;
    localparam int          MAX_STALL = 15;
    localparam logic [15:0] SEED      = 16'hACE1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           inject_en = 1'b0;
    logic [39:0]    stall_thresh = '0;
    logic [159:0]   stall_cnt;
    logic [4:0]     tb_sv = '0;   // source valids {B,W,AW,R,AR}
    logic [4:0]     tb_dr = '0;   // destination readies
    logic [4:0]     dut_dv, dut_sr;

    logic [IW-1:0]  s_arid = '0, s_awid = '0, m_rid = '0, m_bid = '0;
    logic [AWD-1:0] s_araddr = '0, s_awaddr = '0;
    logic [7:0]     s_arlen = '0, s_awlen = '0;
    logic [2:0]     s_arsize = '0, s_awsize = '0, s_arprot = '0, s_awprot = '0;
    logic [1:0]     s_arburst = '0, s_awburst = '0, m_rresp = '0, m_bresp = '0;
    logic           s_arlock = 1'b0, s_awlock = 1'b0, s_wlast = 1'b0, m_rlast = 1'b0;
    logic [3:0]     s_arcache = '0, s_awcache = '0;
    logic [DW-1:0]  s_wdata = '0, m_rdata = '0;
    logic [SW-1:0]  s_wstrb = '0;

    logic [IW-1:0]  m_axi_arid, m_axi_awid, s_axi_rid, s_axi_bid;
    logic [AWD-1:0] m_axi_araddr, m_axi_awaddr;
    logic [7:0]     m_axi_arlen, m_axi_awlen;
    logic [2:0]     m_axi_arsize, m_axi_awsize, m_axi_arprot, m_axi_awprot;
    logic [1:0]     m_axi_arburst, m_axi_awburst, s_axi_rresp, s_axi_bresp;
    logic           m_axi_arlock, m_axi_awlock, m_axi_wlast, s_axi_rlast;
    logic [3:0]     m_axi_arcache, m_axi_awcache;
    logic [DW-1:0]  m_axi_wdata, s_axi_rdata;
    logic [SW-1:0]  m_axi_wstrb;

    axi_stall_injector #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .ID_WIDTH(IW), .STRB_WIDTH(SW),
        .LFSR_SEED(SEED), .MAX_STALL(MAX_STALL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inject_en(inject_en),
        .stall_thresh(stall_thresh), .stall_cnt(stall_cnt),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock),
        .s_axi_arcache(s_arcache), .s_axi_arprot(s_arprot),
        .s_axi_arvalid(tb_sv[0]), .s_axi_arready(dut_sr[0]),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(dut_dv[0]), .m_axi_arready(tb_dr[0]),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(dut_dv[1]), .s_axi_rready(tb_dr[1]),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
        .m_axi_rlast(m_rlast), .m_axi_rvalid(tb_sv[1]), .m_axi_rready(dut_sr[1]),
        .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen),
        .s_axi_awsize(s_awsize), .s_axi_awburst(s_awburst), .s_axi_awlock(s_awlock),
        .s_axi_awcache(s_awcache), .s_axi_awprot(s_awprot),
        .s_axi_awvalid(tb_sv[2]), .s_axi_awready(dut_sr[2]),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(dut_dv[2]), .m_axi_awready(tb_dr[2]),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
        .s_axi_wvalid(tb_sv[3]), .s_axi_wready(dut_sr[3]),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(dut_dv[3]), .m_axi_wready(tb_dr[3]),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(dut_dv[4]), .s_axi_bready(tb_dr[4]),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp),
        .m_axi_bvalid(tb_sv[4]), .m_axi_bready(dut_sr[4])
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int k);
        return stall_cnt[32*k +: 32];
    endfunction

    // ---------------- reference model ----------------
    // Each channel: a 16-bit Galois LFSR (taps 0xB400), whether a valid is
    // already showing downstream and waiting, the length of the current
    // stall streak, and the total number of stalled cycles.
    logic [15:0] m_lfsr [5];
    bit          m_pend [5];
    int          m_streak [5];
    logic [31:0] m_total [5];

    function automatic logic [15:0] spec_seed(input int k);
        logic [31:0] p;
        logic [15:0] s;
        p = 32'h1F35 * (k + 1);
        s = SEED ^ p[15:0];
        return (s == 16'h0) ? 16'hACE1 : s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_lfsr[k] = spec_seed(k);
            m_pend[k] = 0;
            m_streak[k] = 0;
            m_total[k] = 0;
        end
    endtask

    function automatic logic [4:0] model_open();
        logic [4:0] o;
        for (int k = 0; k < 5; k++) begin
            o[k] = !inject_en || (m_lfsr[k][7:0] >= stall_thresh[8*k +: 8]) ||
                   (m_streak[k] == MAX_STALL) || m_pend[k];
        end
        return o;
    endfunction

    task automatic model_step(input logic [4:0] o);
        for (int k = 0; k < 5; k++) begin
            if (tb_sv[k] && !o[k]) begin
                m_streak[k]++;
                if (m_total[k] != 32'hFFFF_FFFF) m_total[k]++;
            end else if (o[k]) begin
                m_streak[k] = 0;
            end
            if (tb_sv[k] && o[k]) m_pend[k] = !tb_dr[k];
            m_lfsr[k] = m_lfsr[k][0] ? ((m_lfsr[k] >> 1) ^ 16'hB400) : (m_lfsr[k] >> 1);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tb_sv = '0;
        tb_dr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // mode 0: random traffic; 1: fixed pattern; 2: random with inject_en flips
    task automatic run_phase(input string tag, input int n, input int mode);
        bit busy [5];
        logic [4:0] o;
        for (int k = 0; k < 5; k++) busy[k] = 0;
        for (int c = 0; c < n; c++) begin
            if (mode == 2 && $urandom_range(0, 15) == 0) inject_en = ~inject_en;
            for (int k = 0; k < 5; k++) begin
                if (mode == 1) begin
                    tb_sv[k] = 1'b1;
                    tb_dr[k] = ((c + k) % 3) != 0;
                end else begin
                    tb_sv[k] = busy[k] ? 1'b1 : 1'($urandom_range(0, 1));
                    tb_dr[k] = 1'($urandom_range(0, 1));
                end
            end
            #1;
            o = model_open();
            check({tag, "_gate"}, {54'h0, dut_dv, dut_sr}, {54'h0, tb_sv & o, tb_dr & o});
            for (int k = 0; k < 5; k++) busy[k] = tb_sv[k] && !dut_sr[k];
            model_step(o);
            @(negedge clk);
        end
        tb_sv = '0;
        tb_dr = '0;
    endtask

    task automatic check_counts(input string tag);
        for (int k = 0; k < 5; k++) check($sformatf("%s_cnt%0d", tag, k), 64'(cnt_of(k)), 64'(m_total[k]));
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        inj;
        logic [7:0]  th;
        logic        arv, m_arr, m_rv, s_rr;
        logic [31:0] rdata;
        logic [29:0] araddr;
        logic        e_m_arv, e_s_arr, e_s_rv;
        logic [31:0] e_rdata;
        logic [29:0] e_araddr;
    } vec_t;

    vec_t vecs [5];

    // Watchdog: every wait below is bounded, this only guards against a hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int          c;
        bit          found;
        logic [31:0] save [5];
        logic [31:0] mem [16];
        bit          aw_pend, aw_got, b_pend, b_issued;
        int          w_idx, w_cnt, b_cnt, wlast_cnt, extra;
        logic [1:0]  bresp_seen;
        logic [3:0]  bid_seen;
        logic [29:0] awaddr_seen;

        vecs[0] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 30'h123,
                    1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 30'h123};
        vecs[1] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 30'h0456,
                    1'b1, 1'b0, 1'b0, 32'h0, 30'h0456};
        vecs[2] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5555AAAA, 30'h0,
                    1'b0, 1'b1, 1'b1, 32'h5555AAAA, 30'h0};
        vecs[3] = '{1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000001, 30'h3FFFFFFF,
                    1'b1, 1'b1, 1'b1, 32'h00000001, 30'h3FFFFFFF};
        vecs[4] = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 30'h2AAAAAAA,
                    1'b0, 1'b0, 1'b0, 32'h0, 30'h2AAAAAAA};

        // Reset state: valids/readies forced low while rst_n=0.
        tb_sv = '1;
        tb_dr = '1;
        #12;
        check("rst_outputs", {54'h0, dut_dv, dut_sr}, 64'h0);
        do_reset();
        for (int k = 0; k < 5; k++) check($sformatf("rst_cnt%0d", k), 64'(cnt_of(k)), 64'h0);

        // Transparent mode: gating must follow the sources exactly, no stalls.
        inject_en = 1'b0;
        stall_thresh = {5{8'd255}};
        run_phase("transp", 48, 0);
        for (int k = 0; k < 5; k++) check($sformatf("transp_cnt%0d", k), 64'(cnt_of(k)), 64'h0);

        // Table-driven payload and gating vectors.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            inject_en = vecs[i].inj;
            stall_thresh = {5{vecs[i].th}};
            tb_sv = {3'b000, vecs[i].m_rv, vecs[i].arv};
            tb_dr = {3'b000, vecs[i].s_rr, vecs[i].m_arr};
            m_rdata = vecs[i].rdata;
            m_rlast = 1'b1;
            m_rid = 4'hA;
            s_araddr = vecs[i].araddr;
            #1;
            check($sformatf("vec%0d_arvalid", i), 64'(dut_dv[0]), 64'(vecs[i].e_m_arv));
            check($sformatf("vec%0d_arready", i), 64'(dut_sr[0]), 64'(vecs[i].e_s_arr));
            check($sformatf("vec%0d_rvalid", i), 64'(dut_dv[1]), 64'(vecs[i].e_s_rv));
            check($sformatf("vec%0d_rdata", i), 64'(s_axi_rdata), 64'(vecs[i].e_rdata));
            check($sformatf("vec%0d_rlast_rid", i), {59'h0, s_axi_rlast, s_axi_rid},
                  {59'h0, vecs[i].e_s_rv, (vecs[i].e_s_rv ? 4'hA : 4'h0)});
            check($sformatf("vec%0d_araddr", i), 64'(m_axi_araddr), 64'(vecs[i].e_araddr));
            @(negedge clk);
        end
        tb_sv = '0;
        tb_dr = '0;

        // Stall cap: thresh 255, a held AR must get through within 16 cycles.
        do_reset();
        inject_en = 1'b1;
        stall_thresh = {5{8'd255}};
        tb_sv = 5'b00001;
        tb_dr = 5'b00001;
        found = 0;
        c = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            #1;
            if (dut_dv[0]) begin
                found = 1;
                c = i;
            end else begin
                @(negedge clk);
            end
        end
        check("cap_rise_found", 64'(found), 64'h1);
        check("cap_rise_within16", 64'(c <= MAX_STALL), 64'h1);
        check("cap_stall_cnt", 64'(cnt_of(0)), 64'(c));
        @(negedge clk);
        tb_sv = '0;
        tb_dr = '0;

        // Commit: once arvalid is up with arready low, it must never drop.
        do_reset();
        inject_en = 1'b1;
        stall_thresh = {5{8'd128}};
        tb_sv = 5'b00001;
        tb_dr = 5'b00000;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            #1;
            if (dut_dv[0]) found = 1;
            else @(negedge clk);
        end
        check("commit_rise", 64'(found), 64'h1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("commit_hold%0d", i), 64'(dut_dv[0]), 64'h1);
        end
        tb_dr[0] = 1'b1;
        #1;
        check("commit_ready_open", 64'(dut_sr[0]), 64'h1);
        @(negedge clk);
        tb_sv = '0;
        tb_dr = '0;
        #1;
        check("commit_released", 64'(dut_dv[0]), 64'h0);
        @(negedge clk);

        // AW + 8-beat W burst with a small RAM on the m side, one B back.
        do_reset();
        inject_en = 1'b1;
        stall_thresh = {5{8'd128}};
        for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_FFFF;
        s_awaddr = 30'h100;
        s_awlen = 8'd7;
        s_awid = 4'h3;
        s_wstrb = '1;
        aw_pend = 1; aw_got = 0; b_pend = 0; b_issued = 0;
        w_idx = 0; w_cnt = 0; b_cnt = 0; wlast_cnt = 0; extra = 0;
        bresp_seen = 2'h3; bid_seen = 4'h0; awaddr_seen = '0;
        for (int cyc = 0; cyc < 600 && extra < 8; cyc++) begin
            tb_sv[2] = aw_pend;
            tb_sv[3] = (w_idx < 8);
            s_wdata = 32'(w_idx);
            s_wlast = (w_idx == 7);
            tb_sv[4] = b_pend;
            m_bresp = 2'b00;
            m_bid = bid_seen;
            tb_dr[2] = 1'($urandom_range(0, 1));
            tb_dr[3] = 1'($urandom_range(0, 1));
            tb_dr[4] = 1'b1;
            #1;
            if (dut_dv[2] && tb_dr[2]) begin
                aw_got = 1;
                awaddr_seen = m_axi_awaddr;
                bid_seen = m_axi_awid;
            end
            if (tb_sv[2] && dut_sr[2]) aw_pend = 0;
            if (dut_dv[3] && tb_dr[3]) begin
                if (w_cnt < 16) mem[w_cnt] = m_axi_wdata;
                if (m_axi_wlast) wlast_cnt++;
                w_cnt++;
            end
            if (tb_sv[3] && dut_sr[3]) w_idx++;
            if (tb_sv[4] && dut_sr[4]) b_pend = 0;
            if (dut_dv[4] && tb_dr[4]) begin
                b_cnt++;
                bresp_seen = s_axi_bresp;
            end
            if (aw_got && w_cnt == 8 && !b_issued) begin
                b_pend = 1;
                b_issued = 1;
            end
            if (b_cnt > 0) extra++;
            @(negedge clk);
        end
        tb_sv = '0;
        tb_dr = '0;
        check("burst_awaddr", 64'(awaddr_seen), 64'h100);
        check("burst_w_beats", 64'(w_cnt), 64'd8);
        check("burst_wlast", 64'(wlast_cnt), 64'd1);
        for (int i = 0; i < 8; i++) check($sformatf("burst_mem%0d", i), 64'(mem[i]), 64'(i));
        check("burst_b_count", 64'(b_cnt), 64'd1);
        check("burst_bresp", 64'(bresp_seen), 64'h0);

        // Randomized traffic, random thresholds, inject_en toggling.
        do_reset();
        inject_en = 1'b1;
        stall_thresh = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                        8'($urandom_range(0, 255)), 8'($urandom_range(128, 255)),
                        8'($urandom_range(200, 255))};
        run_phase("rand", 400, 2);
        check_counts("rand");

        // Asynchronous reset mid-traffic: outputs and counters clear at once.
        tb_sv = '1;
        tb_dr = '1;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {54'h0, dut_dv, dut_sr}, 64'h0);
        for (int k = 0; k < 5; k++) check($sformatf("async_rst_cnt%0d", k), 64'(cnt_of(k)), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        inject_en = 1'b1;
        stall_thresh = {5{8'd160}};
        run_phase("post_rst", 200, 0);
        check_counts("post_rst");

        // Seed determinism with thresh 64, then thresh 0 never stalls.
        do_reset();
        stall_thresh = {5{8'd64}};
        inject_en = 1'b1;
        run_phase("det_a", 80, 1);
        check_counts("det_a");
        for (int k = 0; k < 5; k++) save[k] = cnt_of(k);
        do_reset();
        run_phase("det_b", 80, 1);
        for (int k = 0; k < 5; k++) check($sformatf("det_same%0d", k), 64'(cnt_of(k)), 64'(save[k]));
        do_reset();
        stall_thresh = '0;
        run_phase("thr0", 60, 0);
        for (int k = 0; k < 5; k++) check($sformatf("thr0_cnt%0d", k), 64'(cnt_of(k)), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
